// File: rtl/pulse_period_meter.sv
// Measures the clk-cycle interval between rising edges of pulse_in and offers each result
// on a valid/ready port, with timeout and overrun strobes.
module pulse_period_meter #(
    parameter int               WIDTH       = 16,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] TIMEOUT     = 16'hFFFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pulse_in,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    input  logic             period_ready,
    output logic             active,
    output logic             timeout,
    output logic             overrun
);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   rise;
    logic [WIDTH-1:0]       cnt;
    state_t                 state;

    // pulse_in may be asynchronous; the fixed synchroniser latency cancels out of every interval
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~edge_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            active       <= 1'b0;
            timeout      <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            timeout <= 1'b0;
            overrun <= 1'b0;
            if (period_valid && period_ready) begin
                period_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (rise) begin
                        state  <= MEASURE;
                        active <= 1'b1;
                        cnt    <= CNT_ONE;
                    end
                end
                MEASURE: begin
                    // a capture overrides the handshake clear above, so a simultaneous accept keeps valid high
                    if (rise) begin
                        period       <= cnt;
                        period_valid <= 1'b1;
                        cnt          <= CNT_ONE;
                        overrun      <= period_valid & ~period_ready;
                    end else if (cnt == TIMEOUT) begin
                        timeout <= 1'b1;
                        cnt     <= '0;
                        state   <= IDLE;
                        active  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter: one instance with the default timeout and one
// with TIMEOUT=100, sharing clock, reset and stimulus.
module tb_pulse_period_meter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pulse_in = 1'b0;
    logic        period_ready = 1'b1;

    logic [15:0] period_a, period_b;
    logic        valid_a, valid_b, active_a, active_b;
    logic        timeout_a, timeout_b, overrun_a, overrun_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rise = 0;
    int timeouts_a = 0;
    int timeouts_b = 0;
    int overruns_a = 0;
    int ready_mark = 0;

    typedef struct {
        int   gap;
        logic ready;
        logic exp_valid;
        int   exp_period;
        int   exp_overruns;
        logic exp_valid_next;
    } vec_t;

    vec_t vecs[6];

    pulse_period_meter dut_a (
        .clk(clk), .reset(reset), .pulse_in(pulse_in),
        .period(period_a), .period_valid(valid_a), .period_ready(period_ready),
        .active(active_a), .timeout(timeout_a), .overrun(overrun_a)
    );

    pulse_period_meter #(.WIDTH(16), .SYNC_STAGES(2), .TIMEOUT(16'd100)) dut_b (
        .clk(clk), .reset(reset), .pulse_in(pulse_in),
        .period(period_b), .period_valid(valid_b), .period_ready(period_ready),
        .active(active_b), .timeout(timeout_b), .overrun(overrun_b)
    );

    always #5 clk = ~clk;

    // every clock advance goes through here so one-cycle strobes are never missed
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (timeout_a) timeouts_a++;
        if (timeout_b) timeouts_b++;
        if (overrun_a) overruns_a++;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // pulse rises gap cycles after the previous one; returns one cycle before the capture edge
    task automatic raiseEdge(input int gap);
        while (cyc - last_rise < gap) step();
        pulse_in = 1'b1;
        last_rise = cyc;
        step();
        pulse_in = 1'b0;
        step();
    endtask

    task automatic doReset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        timeouts_a = 0;
        timeouts_b = 0;
        overruns_a = 0;
        step();
        last_rise = cyc;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        period_ready = v.ready;
        raiseEdge(v.gap);
        step();
        checkOutput($sformatf("vec%0d valid", idx), 32'(valid_a), 32'(v.exp_valid));
        checkOutput($sformatf("vec%0d period", idx), 32'(period_a), 32'(v.exp_period));
        checkOutput($sformatf("vec%0d overruns", idx), 32'(overruns_a), 32'(v.exp_overruns));
        checkOutput($sformatf("vec%0d active", idx), 32'(active_a), 32'd1);
        step();
        checkOutput($sformatf("vec%0d valid_next", idx), 32'(valid_a), 32'(v.exp_valid_next));
    endtask

    initial begin
        vecs[0] = '{gap: 10, ready: 1'b1, exp_valid: 1'b0, exp_period: 0,  exp_overruns: 0, exp_valid_next: 1'b0};
        vecs[1] = '{gap: 10, ready: 1'b1, exp_valid: 1'b1, exp_period: 10, exp_overruns: 0, exp_valid_next: 1'b0};
        vecs[2] = '{gap: 10, ready: 1'b1, exp_valid: 1'b1, exp_period: 10, exp_overruns: 0, exp_valid_next: 1'b0};
        vecs[3] = '{gap: 10, ready: 1'b0, exp_valid: 1'b1, exp_period: 10, exp_overruns: 0, exp_valid_next: 1'b1};
        vecs[4] = '{gap: 12, ready: 1'b0, exp_valid: 1'b1, exp_period: 12, exp_overruns: 1, exp_valid_next: 1'b1};
        vecs[5] = '{gap: 14, ready: 1'b0, exp_valid: 1'b1, exp_period: 14, exp_overruns: 2, exp_valid_next: 1'b1};

        #2;
        checkOutput("async reset period", 32'(period_a), 32'd0);
        checkOutput("async reset valid", 32'(valid_a), 32'd0);
        doReset();
        checkOutput("reset active", 32'(active_a), 32'd0);
        checkOutput("reset timeout", 32'(timeout_a), 32'd0);
        checkOutput("reset overrun", 32'(overrun_a), 32'd0);

        // steady 10-cycle ticks, then overruns with ready low
        for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);
        period_ready = 1'b1;
        step();
        checkOutput("t4 valid drop", 32'(valid_a), 32'd0);
        checkOutput("t4 timeouts", 32'(timeouts_a), 32'd0);

        // capture coincides with an accept
        period_ready = 1'b0;
        raiseEdge(10);
        step();
        checkOutput("t5 first period", 32'(period_a), 32'd10);
        checkOutput("t5 first valid", 32'(valid_a), 32'd1);
        raiseEdge(15);
        period_ready = 1'b1;
        ready_mark = overruns_a;
        step();
        period_ready = 1'b0;
        checkOutput("t5 new period", 32'(period_a), 32'd15);
        checkOutput("t5 valid held", 32'(valid_a), 32'd1);
        checkOutput("t5 no overrun", 32'(overruns_a), 32'(ready_mark));
        step();
        checkOutput("t5 valid after", 32'(valid_a), 32'd1);

        // asynchronous reset mid-measurement with a pending result
        #3;
        reset = 1'b1;
        #1;
        checkOutput("t6 period", 32'(period_a), 32'd0);
        checkOutput("t6 valid", 32'(valid_a), 32'd0);
        checkOutput("t6 active", 32'(active_a), 32'd0);
        step();
        step();
        reset = 1'b0;
        period_ready = 1'b1;
        step();
        last_rise = cyc;
        raiseEdge(0);
        step();
        checkOutput("t6 first edge valid", 32'(valid_a), 32'd0);
        checkOutput("t6 first edge active", 32'(active_a), 32'd1);
        raiseEdge(8);
        step();
        checkOutput("t6 second period", 32'(period_a), 32'd8);
        checkOutput("t6 second valid", 32'(valid_a), 32'd1);

        // shortest interval, then exactly TIMEOUT (edge wins over timeout)
        doReset();
        raiseEdge(0);
        raiseEdge(2);
        step();
        checkOutput("t2 period 2", 32'(period_a), 32'd2);
        checkOutput("t2 valid 2", 32'(valid_a), 32'd1);
        raiseEdge(65535);
        step();
        checkOutput("t2 period max", 32'(period_a), 32'd65535);
        checkOutput("t2 valid max", 32'(valid_a), 32'd1);
        checkOutput("t2 no timeout", 32'(timeouts_a), 32'd0);
        checkOutput("t2 still active", 32'(active_a), 32'd1);

        // timeout on the TIMEOUT=100 instance
        doReset();
        raiseEdge(0);
        while (cyc < last_rise + 102) step();
        checkOutput("t3 before timeout", 32'(timeout_b), 32'd0);
        checkOutput("t3 active before", 32'(active_b), 32'd1);
        checkOutput("t3 count before", 32'(timeouts_b), 32'd0);
        step();
        checkOutput("t3 timeout strobe", 32'(timeout_b), 32'd1);
        checkOutput("t3 active after", 32'(active_b), 32'd0);
        step();
        checkOutput("t3 strobe width", 32'(timeout_b), 32'd0);
        checkOutput("t3 count after", 32'(timeouts_b), 32'd1);
        raiseEdge(150);
        step();
        checkOutput("t3 restart valid", 32'(valid_b), 32'd0);
        checkOutput("t3 restart active", 32'(active_b), 32'd1);
        raiseEdge(20);
        step();
        checkOutput("t3 period", 32'(period_b), 32'd20);
        checkOutput("t3 valid", 32'(valid_b), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
